// File: rtl/branch_predictor_gshare_spec.sv
// Gshare direction predictor: PC xor speculative global history indexes a table
// of saturating counters, initialised by a sweep after every reset.
package branch_predictor_gshare_spec_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome_e;
endpackage

module branch_predictor_gshare_spec
  import branch_predictor_gshare_spec_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned HIST_WIDTH  = 8,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned PC_LSB      = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output branch_outcome_e       o_req_prediction,
  output logic [HIST_WIDTH-1:0] o_req_ghr,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [HIST_WIDTH-1:0] i_fb_ghr,
  input  branch_outcome_e       i_fb_prediction,
  input  branch_outcome_e       i_fb_outcome,
  output logic                  o_ready,
  output logic [31:0]           o_mispredict_cnt
);

  localparam int unsigned ENTRIES = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_idx_q, init_idx_d;
  logic [HIST_WIDTH-1:0]  spec_ghr_q, spec_ghr_d;
  logic [31:0]            mis_cnt_q, mis_cnt_d;
  logic                   ready_q;

  logic [CTR_WIDTH-1:0]   table_q [ENTRIES];

  logic [INDEX_WIDTH-1:0] req_idx, fb_idx, wr_idx;
  logic [CTR_WIDTH-1:0]   req_ctr, fb_ctr, wr_val;
  logic                   wr_en;
  logic                   running, pred_taken, fb_fire, mispredict;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^{i_req_pc, i_fb_pc};

  assign running    = (state_q == ST_RUN);
  assign req_idx    = i_req_pc[PC_LSB +: INDEX_WIDTH] ^ INDEX_WIDTH'(spec_ghr_q);
  assign fb_idx     = i_fb_pc[PC_LSB +: INDEX_WIDTH] ^ INDEX_WIDTH'(i_fb_ghr);
  assign req_ctr    = table_q[req_idx];
  assign fb_ctr     = table_q[fb_idx];
  assign pred_taken = running & req_ctr[CTR_WIDTH-1];
  assign fb_fire    = running & i_fb_valid;
  assign mispredict = fb_fire & (i_fb_prediction != i_fb_outcome);

  // Prediction reads the table before any same-cycle feedback write lands.
  assign o_req_prediction = branch_outcome_e'(pred_taken);
  assign o_req_ghr        = spec_ghr_q;
  assign o_ready          = ready_q;
  assign o_mispredict_cnt = mis_cnt_q;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    spec_ghr_d = spec_ghr_q;
    mis_cnt_d  = mis_cnt_q;
    wr_en      = 1'b0;
    wr_idx     = fb_idx;
    wr_val     = fb_ctr;
    case (state_q)
      ST_INIT: begin
        wr_en      = 1'b1;
        wr_idx     = init_idx_q;
        wr_val     = CTR_WNT;
        init_idx_d = init_idx_q + INDEX_WIDTH'(1);
        if (init_idx_q == INDEX_WIDTH'(ENTRIES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fb_fire) begin
          wr_en = 1'b1;
          if (i_fb_outcome == TAKEN) begin
            if (fb_ctr != CTR_MAX) wr_val = fb_ctr + CTR_WIDTH'(1);
          end else begin
            if (fb_ctr != '0) wr_val = fb_ctr - CTR_WIDTH'(1);
          end
        end
        // Recovery from the resolved branch's snapshot wins over a speculative shift.
        if (mispredict) begin
          spec_ghr_d = HIST_WIDTH'({i_fb_ghr, i_fb_outcome == TAKEN});
          if (mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
        end else if (i_req_valid) begin
          spec_ghr_d = HIST_WIDTH'({spec_ghr_q, pred_taken});
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      spec_ghr_q <= '0;
      mis_cnt_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      spec_ghr_q <= spec_ghr_d;
      mis_cnt_q  <= mis_cnt_d;
      ready_q    <= (state_d == ST_RUN);
    end
  end

  // Table contents survive reset; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_val;
  end

endmodule

// File: tb/tb_branch_predictor_gshare_spec.sv
// Randomised scoreboard bench for the gshare predictor against an array-based model.
module tb_branch_predictor_gshare_spec;
  import branch_predictor_gshare_spec_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic [31:0]     req_pc;
  branch_outcome_e req_pred;
  logic [7:0]      req_ghr;
  logic            fb_valid;
  logic [31:0]     fb_pc;
  logic [7:0]      fb_ghr;
  branch_outcome_e fb_pred;
  branch_outcome_e fb_out;
  logic            ready;
  logic [31:0]     mis_cnt;

  branch_predictor_gshare_spec dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_pc(req_pc),
    .o_req_prediction(req_pred), .o_req_ghr(req_ghr),
    .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_ghr(fb_ghr),
    .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
    .o_ready(ready), .o_mispredict_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    int unsigned ghr;
    bit          rdy;
    longint      cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference state: counter values, history, mispredict count, cycles since reset.
  int          m_ctr [1024];
  int unsigned m_ghr;
  longint      m_cnt;
  int          m_cyc;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_ctr[i] = 1;
    m_ghr = 0;
    m_cnt = 0;
    m_cyc = 0;
  endtask

  task automatic step(input bit rv, input int unsigned rpc, input bit fv,
                      input int unsigned fpc, input int unsigned fg,
                      input bit fp, input bit fo);
    exp_t e;
    int   idx, fidx;
    req_valid = rv;
    req_pc    = rpc;
    fb_valid  = fv;
    fb_pc     = fpc;
    fb_ghr    = 8'(fg);
    fb_pred   = branch_outcome_e'(fp);
    fb_out    = branch_outcome_e'(fo);
    e.rdy  = (m_cyc >= 1024);
    idx    = int'(((rpc >> 2) & 1023) ^ m_ghr);
    e.pred = e.rdy && (m_ctr[idx] >= 2);
    e.ghr  = m_ghr;
    e.cnt  = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (e.rdy) begin
      if (fv) begin
        fidx = int'(((fpc >> 2) & 1023) ^ (fg & 255));
        if (fo) m_ctr[fidx] = (m_ctr[fidx] == 3) ? 3 : m_ctr[fidx] + 1;
        else    m_ctr[fidx] = (m_ctr[fidx] == 0) ? 0 : m_ctr[fidx] - 1;
      end
      if (fv && (fp != fo)) begin
        if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
        m_ghr = ((fg << 1) | int'(fo)) & 255;
      end else if (rv) begin
        m_ghr = ((m_ghr << 1) | int'(e.pred)) & 255;
      end
    end
    m_cyc++;
  endtask

  task automatic rand_step(input int pc_range);
    step(1'($urandom_range(0, 1)), $urandom_range(0, pc_range) << 2,
         1'($urandom_range(0, 1)), $urandom_range(0, pc_range) << 2,
         $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous assert in mid-cycle; outputs must clear without waiting for an edge.
  task automatic assert_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    fb_valid  = 1'b0;
    #1;
    chk("rst_ready", longint'(ready), 0);
    chk("rst_cnt", longint'(mis_cnt), 0);
    chk("rst_ghr", longint'(req_ghr), 0);
    chk("rst_pred", longint'(req_pred), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every non-reset cycle the DUT presents a full output set to compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ready", longint'(ready), longint'(e.rdy));
      chk("mispredict_cnt", longint'(mis_cnt), e.cnt);
      chk("req_ghr", longint'(req_ghr), longint'(e.ghr));
      chk("prediction", longint'(req_pred), longint'(e.pred));
    end
  end

  initial begin
    int unsigned g;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_pc    = '0;
    fb_valid  = 1'b0;
    fb_pc     = '0;
    fb_ghr    = '0;
    fb_pred   = NOT_TAKEN;
    fb_out    = NOT_TAKEN;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // INIT sweep with traffic that must be ignored.
    repeat (1024) rand_step(255);
    step(1, 32'h100, 0, 0, 0, 0, 0);

    // Training at PC 0x100 / history 0, then a recovery that restores history 0.
    repeat (2) step(0, 0, 1, 32'h100, 0, 0, 1);
    step(0, 0, 1, 32'h200, 0, 1, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 32'h100, 0, 1, 1);
    step(1, 32'h100, 0, 0, 0, 0, 0);

    // Speculative history build-up, then recovery with a simultaneous request.
    repeat (3) step(1, $urandom_range(0, 1023) << 2, 0, 0, 0, 0, 0);
    step(1, 32'h40, 1, 32'h80, 32'h01, 1, 0);

    // Same-index collision: request and feedback agree on PC and history.
    g = m_ghr;
    step(1, 32'h300, 1, 32'h300, g, 1, 1);
    g = m_ghr;
    step(1, 32'h300, 1, 32'h300, g, 1, 1);
    step(1, 32'h300, 0, 0, 0, 0, 0);

    repeat (2000) rand_step(63);

    // Reset mid-RUN, reset again mid-INIT, then a full fresh INIT.
    assert_reset();
    repeat (500) rand_step(255);
    assert_reset();
    repeat (1100) rand_step(63);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
